// File: rtl/rpn_pkg.sv
// Shared constants and types for the RPN calculator command path.
package rpn_pkg;

  localparam int unsigned DEPTH_MAX = 11;
  localparam int unsigned DEPTH_W   = $clog2(DEPTH_MAX + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_PUSH = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_PCT   = 8'h25;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FIRE,
    ST_WAIT,
    ST_REPORT
  } state_e;

  typedef enum logic [1:0] {
    PK_NONE,
    PK_CMD,
    PK_REPORT
  } pend_kind_e;

  // Second half of a flush pair: what to do once the literal PUSH completes.
  typedef struct packed {
    pend_kind_e kind;
    logic [2:0] op;
  } pend_op_t;

endpackage

// File: rtl/rpn_dec_accum.sv
// Decimal literal accumulator: acc = acc*10 + digit with sticky overflow drop.
module rpn_dec_accum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              digit_valid,
  input  logic [3:0]        digit,
  input  logic              clear,
  output logic [DATA_W-1:0] acc,
  output logic              pending,
  output logic              ovf_c
);

  localparam int unsigned SUM_W = DATA_W + 4;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              pending_q, pending_d;
  logic              ovf_q, ovf_d;
  logic [SUM_W-1:0]  sum;

  // Next accumulator value; once overflowed, digits are ignored until clear.
  always_comb begin
    sum       = SUM_W'(acc_q) * SUM_W'(10) + SUM_W'(digit);
    acc_d     = acc_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    ovf_c     = 1'b0;
    if (clear) begin
      acc_d     = '0;
      pending_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (digit_valid && !ovf_q) begin
      if (sum[SUM_W-1:DATA_W] != '0) begin
        acc_d     = '0;
        pending_d = 1'b0;
        ovf_d     = 1'b1;
        ovf_c     = 1'b1;
      end else begin
        acc_d     = sum[DATA_W-1:0];
        pending_d = 1'b1;
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign acc     = acc_q;
  assign pending = pending_q;

endmodule

// File: rtl/rpn_cmd_issuer.sv
// Tokenizes an ASCII RPN stream and issues checked commands to the calculator.
module rpn_cmd_issuer
  import rpn_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] calc_in,
  output logic [2:0]        calc_op,
  output logic              calc_apply,
  input  logic [DATA_W-1:0] calc_tail,
  input  logic              calc_valid,
  input  logic              calc_empty,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              res_empty,
  output logic              res_valid
);

  state_e              state_q, state_d;
  pend_op_t            pend_q, pend_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                err_q, err_d;
  logic                s_ready_q, s_ready_d;
  logic [DATA_W-1:0]   calc_in_q, calc_in_d;
  logic [2:0]          calc_op_q, calc_op_d;
  logic                calc_apply_q, calc_apply_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_err_q, res_err_d;
  logic                res_empty_q, res_empty_d;
  logic                res_valid_q, res_valid_d;

  logic                xfer_c, is_digit_c, is_delim_c, is_binop_c, is_pop_c, is_eq_c;
  logic [2:0]          binop_c;
  logic [DATA_W-1:0]   acc_c;
  logic                acc_pending_c, acc_ovf_c;

  // Character classification.
  always_comb begin
    xfer_c     = s_valid & s_ready_q;
    is_digit_c = (s_data >= CH_0) && (s_data <= CH_9);
    is_delim_c = (s_data == CH_SP) || (s_data == CH_CR) || (s_data == CH_LF);
    is_pop_c   = (s_data == CH_D);
    is_eq_c    = (s_data == CH_EQ);
    is_binop_c = 1'b1;
    binop_c    = OP_NOP;
    case (s_data)
      CH_PLUS:  binop_c = OP_ADD;
      CH_MINUS: binop_c = OP_SUB;
      CH_STAR:  binop_c = OP_MUL;
      CH_SLASH: binop_c = OP_DIV;
      CH_PCT:   binop_c = OP_MOD;
      default:  is_binop_c = 1'b0;
    endcase
  end

  rpn_dec_accum #(.DATA_W(DATA_W)) u_accum (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (xfer_c & is_digit_c),
    .digit       (s_data[3:0]),
    .clear       (xfer_c & (is_delim_c | is_binop_c | is_pop_c | is_eq_c)),
    .acc         (acc_c),
    .pending     (acc_pending_c),
    .ovf_c       (acc_ovf_c)
  );

  // Next-state, shadow depth checks and command/result outputs.
  always_comb begin
    logic               push_req;
    logic               push_ok;
    logic               do_report;
    logic [DEPTH_W-1:0] depth_eff;
    pend_kind_e         own_kind;
    logic [2:0]         own_op;

    state_d     = state_q;
    pend_d      = pend_q;
    depth_d     = depth_q;
    err_d       = err_q;
    calc_in_d   = calc_in_q;
    calc_op_d   = calc_op_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_empty_d = res_empty_q;
    push_req    = 1'b0;
    push_ok     = 1'b0;
    do_report   = 1'b0;
    depth_eff   = depth_q;
    own_kind    = PK_NONE;
    own_op      = OP_NOP;

    case (state_q)
      ST_IDLE: begin
        if (xfer_c) begin
          if (is_digit_c) begin
            if (acc_ovf_c) err_d = 1'b1;
          end else if (is_delim_c || is_binop_c || is_pop_c || is_eq_c) begin
            push_req  = acc_pending_c;
            push_ok   = push_req && (depth_q != DEPTH_W'(DEPTH_MAX));
            if (push_req && !push_ok) err_d = 1'b1;
            depth_eff = depth_q + DEPTH_W'(push_ok);
            if (is_binop_c) begin
              own_kind = PK_CMD;
              own_op   = binop_c;
              if (depth_eff < DEPTH_W'(2)) begin
                own_kind = PK_NONE;
                err_d    = 1'b1;
              end
            end else if (is_pop_c) begin
              own_kind = PK_CMD;
              own_op   = OP_POP;
              if (depth_eff == '0) begin
                own_kind = PK_NONE;
                err_d    = 1'b1;
              end
            end else if (is_eq_c) begin
              own_kind = PK_REPORT;
            end
            if (push_ok) begin
              state_d   = ST_SETUP;
              calc_op_d = OP_PUSH;
              calc_in_d = acc_c;
              depth_d   = depth_q + DEPTH_W'(1);
              pend_d    = '{kind: own_kind, op: own_op};
            end else if (own_kind == PK_CMD) begin
              state_d   = ST_SETUP;
              calc_op_d = own_op;
              depth_d   = depth_q - DEPTH_W'(1);
            end else if (own_kind == PK_REPORT) begin
              do_report = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_WAIT;
      ST_WAIT: begin
        // A calculator that disagrees with the shadow depth has lost sync.
        if (!calc_valid || (calc_empty != (depth_q == '0))) err_d = 1'b1;
        if (pend_q.kind == PK_CMD) begin
          state_d   = ST_SETUP;
          calc_op_d = pend_q.op;
          depth_d   = depth_q - DEPTH_W'(1);
        end else if (pend_q.kind == PK_REPORT) begin
          do_report = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        pend_d = '{kind: PK_NONE, op: OP_NOP};
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (do_report) begin
      state_d     = ST_REPORT;
      res_data_d  = calc_tail;
      res_err_d   = err_d;
      res_empty_d = (depth_d == '0);
      err_d       = 1'b0;
    end

    s_ready_d    = (state_d == ST_IDLE);
    calc_apply_d = (state_d == ST_FIRE);
    res_valid_d  = (state_d == ST_REPORT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_q       <= '{kind: PK_NONE, op: OP_NOP};
      depth_q      <= '0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      calc_in_q    <= '0;
      calc_op_q    <= OP_NOP;
      calc_apply_q <= 1'b0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
      res_empty_q  <= 1'b1;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
      s_ready_q    <= s_ready_d;
      calc_in_q    <= calc_in_d;
      calc_op_q    <= calc_op_d;
      calc_apply_q <= calc_apply_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      res_empty_q  <= res_empty_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign calc_in    = calc_in_q;
  assign calc_op    = calc_op_q;
  assign calc_apply = calc_apply_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign res_empty  = res_empty_q;
  assign res_valid  = res_valid_q;

endmodule

// File: tb/tb_rpn_cmd_issuer.sv
// Scoreboard bench for rpn_cmd_issuer with a behavioural calculator attached.
module tb_rpn_cmd_issuer;
  import rpn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] calc_in;
  logic [2:0] calc_op;
  logic       calc_apply;
  logic [7:0] calc_tail;
  logic       calc_valid;
  logic       calc_empty;
  logic [7:0] res_data;
  logic       res_err;
  logic       res_empty;
  logic       res_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rpn_cmd_issuer #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .calc_in    (calc_in),
    .calc_op    (calc_op),
    .calc_apply (calc_apply),
    .calc_tail  (calc_tail),
    .calc_valid (calc_valid),
    .calc_empty (calc_empty),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_empty  (res_empty),
    .res_valid  (res_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- calculator stand-in ----------------
  logic [7:0] cs [0:15];
  logic [4:0] cn;
  logic [7:0] ca, cb;
  assign ca = (cn >= 5'd2) ? cs[4'(cn - 5'd2)] : 8'd0;
  assign cb = (cn >= 5'd1) ? cs[4'(cn - 5'd1)] : 8'd0;

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 8'd0) ? 8'd0 : a / b;
      OP_MOD:  return (b == 8'd0) ? 8'd0 : a % b;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cn <= 5'd0;
      calc_tail <= 8'd0;
      calc_valid <= 1'b1;
      calc_empty <= 1'b1;
    end else if (calc_apply) begin
      if (calc_op == OP_PUSH) begin
        cs[cn[3:0]] <= calc_in;
        cn <= cn + 5'd1;
        calc_tail <= calc_in;
        calc_valid <= 1'b1;
        calc_empty <= 1'b0;
      end else if (calc_op == OP_POP) begin
        cn <= (cn == 5'd0) ? 5'd0 : cn - 5'd1;
        calc_tail <= ca;
        calc_valid <= (cn != 5'd0);
        calc_empty <= (cn <= 5'd1);
      end else if (calc_op != OP_NOP) begin
        if (cn >= 5'd2) cs[4'(cn - 5'd2)] <= alu(calc_op, ca, cb);
        cn <= (cn == 5'd0) ? 5'd0 : cn - 5'd1;
        calc_tail <= alu(calc_op, ca, cb);
        calc_valid <= (cn >= 5'd2) && !(((calc_op == OP_DIV) || (calc_op == OP_MOD)) && (cb == 8'd0));
        calc_empty <= (cn <= 5'd1);
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic [2:0] op; logic [7:0] val; } cmd_t;
  typedef struct { logic [7:0] data; logic err; logic empty; } res_t;
  cmd_t exp_cmd[$];
  res_t exp_res[$];

  int stk[$];
  int m_acc;
  bit m_pend, m_ovf, m_err;
  int m_tail;

  function automatic void m_reset();
    stk.delete();
    exp_cmd.delete();
    exp_res.delete();
    m_acc = 0; m_pend = 0; m_ovf = 0; m_err = 0; m_tail = 0;
  endfunction

  function automatic void m_issue(input logic [2:0] op, input int v);
    int a, b, r;
    exp_cmd.push_back('{op, 8'(v)});
    if (op == OP_PUSH) begin
      stk.push_back(v);
      m_tail = v;
    end else if (op == OP_POP) begin
      void'(stk.pop_back());
      m_tail = (stk.size() > 0) ? stk[$] : 0;
    end else begin
      b = stk.pop_back();
      a = stk.pop_back();
      r = 0;
      case (op)
        OP_ADD: r = (a + b) & 255;
        OP_SUB: r = (a - b) & 255;
        OP_MUL: r = (a * b) & 255;
        OP_DIV: if (b == 0) m_err = 1; else r = a / b;
        default: if (b == 0) m_err = 1; else r = a % b;
      endcase
      stk.push_back(r);
      m_tail = r;
    end
  endfunction

  function automatic void m_flush();
    if (m_pend) begin
      if (stk.size() == DEPTH_MAX) m_err = 1;
      else m_issue(OP_PUSH, m_acc);
    end
    m_acc = 0; m_pend = 0; m_ovf = 0;
  endfunction

  function automatic void m_char(input logic [7:0] c);
    int v;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (!m_ovf) begin
        v = m_acc * 10 + int'(c - 8'h30);
        if (v > 255) begin
          m_ovf = 1; m_err = 1; m_acc = 0; m_pend = 0;
        end else begin
          m_acc = v; m_pend = 1;
        end
      end
    end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
      m_flush();
    end else if (c == "+" || c == "-" || c == "*" || c == "/" || c == "%") begin
      m_flush();
      if (stk.size() < 2) m_err = 1;
      else case (c)
        "+": m_issue(OP_ADD, 0);
        "-": m_issue(OP_SUB, 0);
        "*": m_issue(OP_MUL, 0);
        "/": m_issue(OP_DIV, 0);
        default: m_issue(OP_MOD, 0);
      endcase
    end else if (c == "d") begin
      m_flush();
      if (stk.size() < 1) m_err = 1;
      else m_issue(OP_POP, 0);
    end else if (c == "=") begin
      m_flush();
      exp_res.push_back('{8'(m_tail), m_err, (stk.size() == 0)});
      m_err = 0;
    end else begin
      m_err = 1;
    end
  endfunction

  // Output monitor: compares every strobe against the queued expectation.
  cmd_t mc;
  res_t mr;
  always @(negedge clk) begin
    if (!rst) begin
      if (calc_apply) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected", 32'(calc_op), 32'(8));
        else begin
          mc = exp_cmd.pop_front();
          check("cmd_op", 32'(calc_op), 32'(mc.op));
          if (mc.op == OP_PUSH) check("cmd_in", 32'(calc_in), 32'(mc.val));
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) check("res_unexpected", 32'(res_data), 32'(999));
        else begin
          mr = exp_res.pop_front();
          check("res_data", 32'(res_data), 32'(mr.data));
          check("res_err", 32'(res_err), 32'(mr.err));
          check("res_empty", 32'(res_empty), 32'(mr.empty));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns cycles from acceptance until s_ready is high again.
  task automatic send(input logic [7:0] c, output int lat);
    int guard;
    lat = 0;
    s_data = c;
    s_valid = 1'b1;
    guard = 0;
    while (!s_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      check("ready_timeout", 32'(s_ready), 32'(1));
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m_char(c);
    @(negedge clk);
    s_valid = 1'b0;
    lat = 1;
    while (!s_ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_str(input string s);
    int lat;
    for (int i = 0; i < s.len(); i++) send(s[i], lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(s_ready), 32'(1));
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) return 8'h30 + 8'($urandom_range(0, 9));
    if (r < 63) return CH_SP;
    if (r < 66) return CH_CR;
    if (r < 68) return CH_LF;
    if (r < 82) begin
      case ($urandom_range(0, 4))
        0: return CH_PLUS;
        1: return CH_MINUS;
        2: return CH_STAR;
        3: return CH_SLASH;
        default: return CH_PCT;
      endcase
    end
    if (r < 88) return CH_D;
    if (r < 97) return CH_EQ;
    return 8'h78;
  endfunction

  initial begin
    int lat;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'(0));
    check("rst_calc_apply", 32'(calc_apply), 32'(0));
    check("rst_calc_op", 32'(calc_op), 32'(7));
    check("rst_calc_in", 32'(calc_in), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_data", 32'(res_data), 32'(0));
    check("rst_res_err", 32'(res_err), 32'(0));
    check("rst_res_empty", 32'(res_empty), 32'(1));
    rst = 1'b0;
    @(negedge clk);
    check("ready_first_cycle", 32'(s_ready), 32'(1));

    // Illegal binary op on an empty stack, then a bare report.
    send(CH_PLUS, lat); check("lat_rejected_op", 32'(lat), 32'(1));
    send(CH_EQ, lat);   check("lat_bare_report", 32'(lat), 32'(2));

    // Basic arithmetic with flush pairs.
    send_str("12");
    send(CH_SP, lat);   check("lat_single_cmd", 32'(lat), 32'(4));
    send_str("34");
    send(CH_PLUS, lat); check("lat_flush_pair", 32'(lat), 32'(7));
    send(CH_SP, lat);   check("lat_idle_delim", 32'(lat), 32'(1));
    send_str("=");
    send_str("5 0/=");
    send_str("=");
    send_str("255 1+=");
    send_str("256 =");
    send_str("3 9999 7*d d=");

    // Stack capacity: eleven pushes accepted, the twelfth rejected.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(8'h31, lat);
      send(CH_SP, lat);
      check("lat_cap_push", 32'(lat), (i < 11) ? 32'(4) : 32'(1));
    end
    send_str("=");

    // Reset asserted while a PUSH is in FIRE.
    do_reset();
    send(8'h37, lat);
    s_data = CH_SP;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("apply_in_fire", 32'(calc_apply), 32'(1));
    rst = 1'b1;
    #1;
    check("apply_drop_on_rst", 32'(calc_apply), 32'(0));
    check("ready_low_in_rst", 32'(s_ready), 32'(0));
    do_reset();
    send_str("=");
    send_str("9 4-=");

    // Randomized expressions.
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand_char(), lat);
    end
    send_str(" =");

    repeat (5) @(negedge clk);
    check("cmd_queue_drained", 32'(exp_cmd.size()), 32'(0));
    check("res_queue_drained", 32'(exp_res.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
